cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_ctrl_stats.sv | 26 ++
 rtl/cache_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and cache read latency for cache_ctrl
package cache_pkg;

  // Fixed read latency of the downstream cache, in cycles after the request
  localparam int CACHE_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_RD   = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    WR_MEM   = 3'd5
  } cache_state_t;

endpackage

// File: rtl/cache_ctrl_stats.sv
// rtl/cache_ctrl_stats.sv - saturating read hit/miss counters for cache_ctrl
module cache_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses
);

  // Count lookup outcomes, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit_inc && (stat_hits != 16'hFFFF)) begin
        stat_hits <= stat_hits + 16'd1;
      end
      if (miss_inc && (stat_misses != 16'hFFFF)) begin
        stat_misses <= stat_misses + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - write-through cache controller; stats counters built only with CACHE_CTRL_STATS_EN
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int INDEXW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_hit,
  output logic          cache_valid,
  output logic          cache_write,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_wdata,
  input  logic [DW-1:0] cache_rdata,
  input  logic          cache_ready,
  input  logic          cache_hit,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_write,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_rdata,
  output logic [15:0]   stat_hits,
  output logic [15:0]   stat_misses
);

  localparam int CNTW = (CACHE_RD_LAT > 1) ? $clog2(CACHE_RD_LAT) : 1;

  cache_state_t    state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   data_q;       // last read result; also the fill data
  logic [CNTW-1:0] lat_cnt;
  logic            hit_pulse_q;
  logic            wr_done_q;
  logic            accept;
  logic            lookup_done;
  logic [INDEXW-1:0] lookup_index;

  assign accept       = req_valid && (state == IDLE) && !rst;
  // Lookup window is timed purely by the counter; cache_ready is not trusted
  assign lookup_done  = (state == LOOKUP) && (lat_cnt == CNTW'(CACHE_RD_LAT - 1));
  assign lookup_index = addr_q[INDEXW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = req_write ? WR_MEM : LOOKUP;
      LOOKUP:   if (lookup_done) state_nxt = cache_hit ? IDLE : MEM_RD;
      MEM_RD:   if (mem_req_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid) state_nxt = FILL;
      FILL:     state_nxt = IDLE;
      WR_MEM:   if (mem_req_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request latch, lookup counter, read data capture and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      lat_cnt     <= '0;
      hit_pulse_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      hit_pulse_q <= lookup_done && cache_hit;
      wr_done_q   <= (state == WR_MEM) && mem_req_ready;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state == LOOKUP) && !lookup_done) begin
        lat_cnt <= lat_cnt + CNTW'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (lookup_done && cache_hit) begin
        data_q <= cache_rdata;
      end
      if ((state == MEM_WAIT) && mem_resp_valid) begin
        data_q <= mem_resp_rdata;
      end
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    req_ready     = 1'b0;
    cache_valid   = 1'b0;
    cache_write   = 1'b0;
    cache_addr    = '0;
    cache_wdata   = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    resp_valid    = hit_pulse_q || wr_done_q;
    resp_hit      = hit_pulse_q;
    resp_rdata    = data_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cache_valid = 1'b1;
          cache_write = req_write;
          cache_addr  = req_addr;
          cache_wdata = req_write ? req_wdata : '0;
        end
      end
      MEM_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
      end
      FILL: begin
        cache_valid = 1'b1;
        cache_write = 1'b1;
        cache_addr  = addr_q;
        cache_wdata = data_q;
        resp_valid  = 1'b1;
      end
      WR_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
      end
      default: ;
    endcase
    if (rst) begin
      req_ready     = 1'b0;
      cache_valid   = 1'b0;
      cache_write   = 1'b0;
      cache_addr    = '0;
      cache_wdata   = '0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_rdata    = '0;
    end
  end

  // The cache must present its result when the lookup window closes
  always_ff @(posedge clk) begin
    if (!rst && lookup_done) begin
      assert (cache_ready)
        else $error("cache_ready low at lookup of index %0d", lookup_index);
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hits_cnt;
  logic [15:0] misses_cnt;

  cache_ctrl_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .hit_inc     (lookup_done && cache_hit),
    .miss_inc    (lookup_done && !cache_hit),
    .stat_hits   (hits_cnt),
    .stat_misses (misses_cnt)
  );

  assign stat_hits   = rst ? 16'd0 : hits_cnt;
  assign stat_misses = rst ? 16'd0 : misses_cnt;
`else
  assign stat_hits   = 16'd0;
  assign stat_misses = 16'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with cache/memory models and a reference model
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        cache_valid;
  logic        cache_write;
  logic [9:0]  cache_addr;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata = '0;
  logic        cache_ready = 1'b0;
  logic        cache_hit = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_write;
  logic [9:0]  mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;

  cache_ctrl #(.AW(10), .DW(32), .INDEXW(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .cache_valid(cache_valid), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A5A0000 + 32'(a) * 32'd7919;
  endfunction

  // Reference model: memory contents plus which address owns each cache index
  typedef struct { bit hit; logic [31:0] data; int lat_cyc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem[int];
  int          resident[int];
  logic [31:0] ref_last = '0;
  int          ref_hits = 0;
  int          ref_misses = 0;

  function automatic logic [31:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic ref_issue(input bit wr, input logic [9:0] a, input logic [31:0] d, input int acc_cyc);
    exp_t e;
    int idx;
    idx = int'(a[5:0]);
    if (wr) begin
      ref_mem[int'(a)] = d;
      resident[idx] = int'(a);
      e.hit = 1'b0; e.data = ref_last; e.lat_cyc = -1;
    end else begin
      e.data = ref_get(int'(a));
      if (resident.exists(idx) && resident[idx] == int'(a)) begin
        e.hit = 1'b1; e.lat_cyc = acc_cyc + 3;
        if (ref_hits < 65535) ref_hits++;
      end else begin
        e.hit = 1'b0; e.lat_cyc = -1;
        if (ref_misses < 65535) ref_misses++;
      end
      resident[idx] = int'(a);
      ref_last = e.data;
    end
    exp_q.push_back(e);
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_hit", 64'(resp_hit), 64'(e.hit));
        chk("resp_rdata", 64'(resp_rdata), 64'(e.data));
        if (e.lat_cyc >= 0) chk("hit_latency", 64'(cyc), 64'(e.lat_cyc));
      end
    end
  end

  // Cache model: direct-mapped, 2-cycle read latency, contents only from DUT writes
  logic [3:0]  ctag[64];
  bit          cvalid[64];
  logic [31:0] cdata[64];
  bit          s0_v = 0, s1_v = 0, s0_h = 0, s1_h = 0;
  logic [31:0] s0_d = '0, s1_d = '0;
  logic [9:0]  last_cw_addr = '0;
  logic [31:0] last_cw_data = '0;
  int          cw_count = 0;

  initial begin : cache_bfm
    int idx;
    forever begin
      @(negedge clk);
      cache_ready = s1_v; cache_hit = s1_h; cache_rdata = s1_d;
      s1_v = s0_v; s1_h = s0_h; s1_d = s0_d;
      s0_v = 1'b0; s0_h = 1'b0; s0_d = 32'($urandom);
      if (cache_valid === 1'b1) begin
        idx = int'(cache_addr[5:0]);
        s0_v = 1'b1;
        if (cache_write) begin
          ctag[idx] = cache_addr[9:6]; cvalid[idx] = 1'b1; cdata[idx] = cache_wdata;
          last_cw_addr = cache_addr; last_cw_data = cache_wdata; cw_count++;
          s0_h = 1'b1;
        end else begin
          s0_h = cvalid[idx] && (ctag[idx] == cache_addr[9:6]);
          if (s0_h) s0_d = cdata[idx];
        end
      end
    end
  end

  // Backing memory model with random ready, random read delay and optional stall
  logic [31:0] bfm_mem[int];
  bit          pend = 0, bfm_hold = 0, noise_en = 0, stall_armed = 0;
  int          pend_dly = 0, stall_left = 0;
  logic [9:0]  pend_addr = '0, last_rd_addr = '0, run_addr = '0;
  logic [31:0] run_wdata = '0;
  bit          run_write = 0, run_unstable = 0, run_rdy = 0;
  bit          last_unstable = 0, last_rdy = 0;
  int          run_len = 0, last_run_len = 0, rd_count = 0, mem_valid_cycles = 0;

  initial begin : mem_bfm
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend && !bfm_hold) begin
        if (pend_dly == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = bfm_mem.exists(int'(pend_addr)) ? bfm_mem[int'(pend_addr)] : init_val(int'(pend_addr));
          pend = 0;
        end else pend_dly--;
      end else if (!pend && noise_en && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'($urandom);
      end
      if (stall_left > 0) mem_req_ready = 1'b0;
      else mem_req_ready = stall_armed ? 1'b1 : 1'($urandom_range(0, 1));
      if (mem_req_valid === 1'b1) begin
        mem_valid_cycles++;
        if (run_len > 0 && (mem_req_addr !== run_addr || mem_req_wdata !== run_wdata || mem_req_write !== run_write))
          run_unstable = 1;
        if (req_ready === 1'b1) run_rdy = 1;
        run_addr = mem_req_addr; run_wdata = mem_req_wdata; run_write = mem_req_write;
        run_len++;
        if (stall_left > 0) stall_left--;
        if (mem_req_ready) begin
          last_run_len = run_len; last_unstable = run_unstable; last_rdy = run_rdy;
          run_len = 0; run_unstable = 0; run_rdy = 0; stall_armed = 0;
          if (mem_req_write) bfm_mem[int'(mem_req_addr)] = mem_req_wdata;
          else begin
            pend = 1; pend_dly = $urandom_range(0, 3);
            pend_addr = mem_req_addr; last_rd_addr = mem_req_addr; rd_count++;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic do_req(input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input bit use_ref, input bit wait_done);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
    end else if (use_ref) ref_issue(wr, a, d, cyc);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 10'($urandom); req_wdata = 32'($urandom);
    if (wait_done) wait_idle();
  endtask

  initial begin : stim
    int mv, rc, n;
    bit saw_resp, saw_cw;
    logic [9:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_cache_valid", 64'(cache_valid), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_stats", 64'({stat_hits, stat_misses}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Cold read miss, then hit
    bfm_mem[32'h045] = 32'hDEADBEEF;
    ref_mem[32'h045] = 32'hDEADBEEF;
    do_req(0, 10'h045, '0, 1, 1);
    chk("cold_mem_addr", 64'(last_rd_addr), 64'h045);
    chk("cold_fill_addr", 64'(last_cw_addr), 64'h045);
    chk("cold_fill_data", 64'(last_cw_data), 64'hDEADBEEF);
    mv = mem_valid_cycles;
    do_req(0, 10'h045, '0, 1, 1);
    chk("hit_no_mem_req", 64'(mem_valid_cycles - mv), 64'd0);

    // Conflict on index 5
    do_req(0, 10'h085, '0, 1, 1);
    chk("conflict_mem_addr", 64'(last_rd_addr), 64'h085);
    do_req(0, 10'h045, '0, 1, 1);
    chk("conflict_remiss_addr", 64'(last_rd_addr), 64'h045);

    // Write with three stalled memory cycles, then read back
    stall_left = 3; stall_armed = 1;
    do_req(1, 10'h010, 32'h12345678, 1, 1);
    chk("stall_len", 64'(last_run_len), 64'd4);
    chk("stall_stable", 64'(last_unstable), 64'd0);
    chk("stall_req_ready", 64'(last_rdy), 64'd0);
    do_req(0, 10'h010, '0, 1, 1);

`ifdef CACHE_CTRL_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'd2);
    chk("stat_misses", 64'(stat_misses), 64'd3);
`else
    chk("stat_hits", 64'(stat_hits), 64'd0);
    chk("stat_misses", 64'(stat_misses), 64'd0);
`endif

    // Reset while waiting on memory; the late response must be ignored
    bfm_hold = 1;
    rc = rd_count;
    do_req(0, 10'h1C3, '0, 0, 0);
    n = 0;
    while (rd_count == rc && n < 100) begin @(negedge clk); n++; end
    chk("rst_test_mem_req_seen", 64'(rd_count - rc), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    ref_last = '0; ref_hits = 0; ref_misses = 0;
    bfm_hold = 0;
    saw_resp = 0; saw_cw = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw_resp = 1;
      if (cache_valid === 1'b1) saw_cw = 1;
    end
    chk("late_resp_no_resp", 64'(saw_resp), 64'd0);
    chk("late_resp_no_cache_wr", 64'(saw_cw), 64'd0);
    chk("late_resp_req_ready", 64'(req_ready), 64'd1);
    chk("late_resp_rdata", 64'(resp_rdata), 64'd0);

    // Randomized traffic over a small address set to mix hits, misses and conflicts
    noise_en = 1;
    for (int i = 0; i < 80; i++) begin
      a = 10'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      do_req(1'($urandom_range(0, 9) < 3), a, 32'($urandom), 1, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    noise_en = 0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef CACHE_CTRL_STATS_EN
    chk("final_stat_hits", 64'(stat_hits), 64'(ref_hits));
    chk("final_stat_misses", 64'(stat_misses), 64'(ref_misses));
`else
    chk("final_stat_hits", 64'(stat_hits), 64'd0);
    chk("final_stat_misses", 64'(stat_misses), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
